// File: rtl/cnn_mem_pkg.sv
// ---------------------------------------------------------------------------
// cnn_mem_pkg
// Shared definitions for the CNN feature-map memory blocks: default
// Convolution 1 geometry, the conv1 result word type, the write-side FSM
// state encoding and a counter-width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package cnn_mem_pkg;

   localparam int CONV1_W      = 24;
   localparam int CONV1_H      = 24;
   localparam int CONV1_MAPS   = 1;
   localparam int CONV1_DATA_W = 16;

   typedef logic [CONV1_DATA_W-1:0] conv1_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } conv1_state_t;

   // Width of a counter that must hold 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/mem_wrap_counter.sv
// ---------------------------------------------------------------------------
// mem_wrap_counter
// Modulo-MAX up-counter used to walk column/row/map positions. Chains by
// feeding one counter's wrap into the next counter's en.
// Ports:
//   clk    in   clock, state updates on the falling edge
//   reset  in   asynchronous, active-high
//   en     in   advance by one
//   clr    in   synchronous clear to zero (wins over en)
//   value  out  current count, 0..MAX-1
//   wrap   out  combinational: en is high and value is at MAX-1
// ---------------------------------------------------------------------------
module mem_wrap_counter
   import cnn_mem_pkg::*;
#(
   parameter int MAX = 24,
   parameter int W   = cnt_width(MAX)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] value,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] value_r;
   logic         wrap_s;

   // Terminal-count detect, qualified by en so it can drive the next stage.
   always_comb begin
      wrap_s = 1'b0;
      if (en && (value_r == LAST)) begin
         wrap_s = 1'b1;
      end else begin
         wrap_s = 1'b0;
      end
   end

   // Count register: clear, then advance-with-wrap, else hold.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         value_r <= '0;
      end else if (clr) begin
         value_r <= '0;
      end else if (en) begin
         if (wrap_s) begin
            value_r <= '0;
         end else begin
            value_r <= value_r + W'(1);
         end
      end else begin
         value_r <= value_r;
      end
   end

   assign value = value_r;
   assign wrap  = wrap_s;

endmodule

// File: rtl/conv1_mem_write.sv
// ---------------------------------------------------------------------------
// conv1_mem_write
// Write-side addresser for the Convolution 1 output memory. Accepts conv1
// results as a valid/ready raster-order stream and drives registered write
// address/data/enable into the feature-map RAM. State changes on the falling
// clock edge so the RAM sees the write on the following rising edge.
// Ports:
//   clk             in   clock (state updates on falling edge)
//   reset           in   asynchronous, active-high
//   start           in   begin a frame (honoured in IDLE/DONE only)
//   in_valid        in   conv1 result present
//   in_data         in   conv1 result
//   in_ready        out  high exactly while writing a frame
//   mem_addr        out  registered write address
//   mem_wdata       out  registered write data
//   mem_we          out  registered write enable
//   pool_row_ready  out  one-cycle pulse after an odd row's last column
//   done            out  frame complete, held until the next start
//   err             out  sticky: data offered while not writing
// ---------------------------------------------------------------------------
module conv1_mem_write
   import cnn_mem_pkg::*;
#(
   parameter int IMG_W    = CONV1_W,
   parameter int IMG_H    = CONV1_H,
   parameter int NUM_MAPS = CONV1_MAPS,
   parameter int DATA_W   = CONV1_DATA_W,
   parameter int ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              pool_row_ready,
   output logic              done,
   output logic              err
);

   localparam int CW = cnt_width(IMG_W);
   localparam int RW = cnt_width(IMG_H);
   localparam int MW = cnt_width(NUM_MAPS);

   localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] MAP_STRIDE = ADDR_W'(IMG_W * IMG_H);

   // Reject configurations the address bus or the row-pair pulse cannot serve.
   generate
      if (ADDR_W < $clog2(NUM_MAPS * IMG_W * IMG_H)) begin : g_addr_too_narrow
         $error("conv1_mem_write: ADDR_W too small for NUM_MAPS*IMG_W*IMG_H");
      end
      if ((IMG_H % 2) != 0) begin : g_height_odd
         $error("conv1_mem_write: IMG_H must be even");
      end
   endgenerate

   conv1_state_t      state_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              mem_we_r;
   logic              pool_r;
   logic              done_r;
   logic              err_r;

   logic              writing_s;
   logic              accept_s;
   logic              clr_s;
   logic [CW-1:0]     col_s;
   logic [RW-1:0]     row_s;
   logic [MW-1:0]     map_s;
   logic              col_wrap_s;
   logic              row_wrap_s;
   logic              map_wrap_s;
   logic [ADDR_W-1:0] addr_s;

   // Handshake, frame-start clear and flat address of the current beat.
   always_comb begin
      writing_s = 1'b0;
      accept_s  = 1'b0;
      clr_s     = 1'b0;
      addr_s    = '0;
      if (state_r == WRITE) begin
         writing_s = 1'b1;
      end else begin
         writing_s = 1'b0;
      end
      accept_s = in_valid && writing_s;
      // Counters restart on the same edge the FSM enters WRITE.
      clr_s    = start && !writing_s;
      addr_s   = (ADDR_W'(map_s) * MAP_STRIDE)
               + (ADDR_W'(row_s) * ROW_STRIDE)
               + ADDR_W'(col_s);
   end

   mem_wrap_counter #(.MAX(IMG_W), .W(CW)) u_col (
      .clk   (clk),
      .reset (reset),
      .en    (accept_s),
      .clr   (clr_s),
      .value (col_s),
      .wrap  (col_wrap_s)
   );

   mem_wrap_counter #(.MAX(IMG_H), .W(RW)) u_row (
      .clk   (clk),
      .reset (reset),
      .en    (col_wrap_s),
      .clr   (clr_s),
      .value (row_s),
      .wrap  (row_wrap_s)
   );

   // A map wrap coincides with accepting the very last beat of the frame.
   mem_wrap_counter #(.MAX(NUM_MAPS), .W(MW)) u_map (
      .clk   (clk),
      .reset (reset),
      .en    (row_wrap_s),
      .clr   (clr_s),
      .value (map_s),
      .wrap  (map_wrap_s)
   );

   // Frame FSM together with all registered RAM-side and status outputs.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         mem_we_r    <= 1'b0;
         pool_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         mem_we_r <= accept_s;
         // Last column of an odd row closes a row pair for pooling.
         pool_r   <= accept_s && col_wrap_s && row_s[0];
         if (accept_s) begin
            mem_addr_r  <= addr_s;
            mem_wdata_r <= in_data;
         end else begin
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
         end
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  state_r <= WRITE;
                  done_r  <= 1'b0;
                  err_r   <= 1'b0;
               end else begin
                  state_r <= state_r;
                  done_r  <= done_r;
                  // Data offered outside a frame is dropped and flagged.
                  err_r   <= err_r || in_valid;
               end
            end
            WRITE: begin
               err_r <= err_r;
               if (accept_s && map_wrap_s) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= WRITE;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               err_r   <= err_r;
            end
         endcase
      end
   end

   assign in_ready       = writing_s;
   assign mem_addr       = mem_addr_r;
   assign mem_wdata      = mem_wdata_r;
   assign mem_we         = mem_we_r;
   assign pool_row_ready = pool_r;
   assign done           = done_r;
   assign err            = err_r;

endmodule
